ecc_177_enc_fault_detc: RTL and testbench
=========================================

ECC_177_ENC_FAULT_DETC -- requirements
Module: ecc_177_enc_fault_detc

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 177, data word width; PARITY_WIDTH, default 9, SECDED check-bit width.
REQ-002 The design SHALL use one clock, clk, and one reset, rst, which is synchronous and active-high.
REQ-003 Ports SHALL be, in order:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ecc_fault_detc_en  in  1  enables the dual-encoder compare
- bypass  in  1  forces parity to zero and suppresses the compare
- fault_inj  in  1  test only; inverts data bit 0 into the shadow encoder
- in_valid  in  1  input word valid
- in_ready  out  1  input accepted when in_valid & in_ready
- data_in  in  DATA_WIDTH  word to encode
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts
- data_out  out  DATA_WIDTH  registered copy of data_in
- parity_out  out  PARITY_WIDTH  check bits, possibly poisoned
- ecc_fault  out  1  compare mismatch for the current output word
- fault_sticky  out  1  latched mismatch status
- fault_clr  in  1  clears fault_sticky and fault_cnt
- fault_cnt  out  8  saturating mismatch count

Function
REQ-004 Codeword positions SHALL run from 1 to 185; data bit k SHALL occupy the (k+1)-th position that is not a power of two.
REQ-005 Parity bit i (i = 0..7) SHALL be the XOR of the data bits whose position has bit i set.
REQ-006 Parity bit 8 SHALL be the XOR of all data bits and parity[7:0].
REQ-007 Two independent encoder instances, primary and shadow, SHALL encode the accepted word; the shadow input is data_in with bit 0 inverted when fault_inj=1.
REQ-008 A mismatch SHALL be declared when ecc_fault_detc_en=1, bypass=0 and the two 9-bit parities differ.
REQ-009 On mismatch, parity_out SHALL be the primary parity with bits 0 and 8 inverted (poison), so any SECDED decoder flags a double-bit error; otherwise parity_out SHALL be the primary parity.
REQ-010 When bypass=1, parity_out SHALL be all zeros and ecc_fault SHALL be 0.
REQ-011 The block SHALL have one pipeline stage; data_out, parity_out and ecc_fault SHALL register on acceptance and appear on the next cycle with out_valid=1.
REQ-012 in_ready SHALL equal ~out_valid | out_ready (combinational), giving full throughput with no bubble under continuous ready.
REQ-013 While out_valid=1 and out_ready=0, data_out, parity_out and ecc_fault SHALL hold stable.
REQ-014 out_valid SHALL clear after a handshake if no new word is accepted in the same cycle.
REQ-015 fault_sticky SHALL set on the cycle ecc_fault is registered high and hold until fault_clr.
REQ-016 fault_cnt SHALL increment once per registered mismatch and saturate at 255.
REQ-017 If fault_clr and a new mismatch occur in the same cycle, fault_sticky SHALL be 1 and fault_cnt SHALL be 1.
REQ-018 ecc_fault_detc_en, bypass and fault_inj SHALL be sampled only on acceptance.

Reset
REQ-019 While rst=1, out_valid, ecc_fault, fault_sticky and fault_cnt SHALL be 0, and data_out and parity_out SHALL be zero.
REQ-020 A word held when rst asserts SHALL be discarded, and in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-021 With ECC_ENC_FAULT_CNT_EN defined, fault_cnt SHALL behave per REQ-016 and REQ-017.
REQ-022 Without ECC_ENC_FAULT_CNT_EN, fault_cnt SHALL be constant 0 and no counter flops SHALL exist; all other behaviour SHALL be unchanged.

Structure
REQ-023 A shared package ecc_177_pkg SHALL hold DATA_WIDTH/PARITY_WIDTH constants, the position map and the parity-generation function, so the decoder side computes identical check bits.
REQ-024 The purely combinational encoder SHALL be a sub-module ecc_177_enc, instantiated twice (u0 primary, u1 shadow).

Verification
REQ-025 A bench SHALL cover data_in=0, en=1 -> one cycle later parity_out=9'h000, ecc_fault=0.
REQ-026 A bench SHALL cover data_in=1 -> parity_out=9'h103.
REQ-027 A bench SHALL cover data_in=1, fault_inj=1, en=1 -> ecc_fault=1, parity_out=9'h002, fault_sticky=1, fault_cnt=1 (with the macro defined).
REQ-028 A bench SHALL cover the same stimulus with en=0 -> ecc_fault=0, parity_out=9'h103, sticky unchanged.
REQ-029 A bench SHALL hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable; then out_ready=1 -> one transfer per cycle in order.
REQ-030 A bench SHALL drive 300 injected mismatches -> fault_cnt=255; then fault_clr together with a further mismatch -> fault_cnt=1, fault_sticky=1.

Source files
------------

// File: rtl/ecc_177_pkg.sv
// Shared constants, data-bit position map and check-bit function for the 177-bit SECDED code.
// The decoder imports this too so both sides derive identical check bits.
package ecc_177_pkg;

    localparam int DATA_WIDTH   = 177;
    localparam int PARITY_WIDTH = 9;
    localparam int CODE_WIDTH   = 185;

    localparam logic [PARITY_WIDTH-1:0] POISON_MASK = 9'h101;

    typedef logic [DATA_WIDTH-1:0][7:0] pos_map_t;

    // Data bit k lands on the (k+1)-th codeword position that is not a power of two.
    function automatic pos_map_t build_pos_map();
        pos_map_t   m;
        logic [7:0] k;
        m = '0;
        k = '0;
        for (int pos = 1; pos <= CODE_WIDTH; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                m[k] = 8'(pos);
                k    = k + 8'd1;
            end
        end
        return m;
    endfunction

    localparam pos_map_t POS_MAP = build_pos_map();

    function automatic logic [PARITY_WIDTH-1:0] ecc_parity(input logic [DATA_WIDTH-1:0] data);
        logic [PARITY_WIDTH-1:0] p;
        p = '0;
        for (int k = 0; k < DATA_WIDTH; k++) begin
            if (data[k]) begin
                p[7:0] = p[7:0] ^ POS_MAP[k];
            end
        end
        p[PARITY_WIDTH-1] = (^data) ^ (^p[7:0]);
        return p;
    endfunction

endpackage

// File: rtl/ecc_177_enc.sv
// Purely combinational SECDED check-bit generator for one 177-bit word.
module ecc_177_enc #(
    parameter int DATA_WIDTH   = ecc_177_pkg::DATA_WIDTH,
    parameter int PARITY_WIDTH = ecc_177_pkg::PARITY_WIDTH
) (
    input  logic [DATA_WIDTH-1:0]   data,
    output logic [PARITY_WIDTH-1:0] parity
);
    import ecc_177_pkg::*;

    assign parity = ecc_parity(data);

endmodule

// File: rtl/ecc_177_enc_fault_detc.sv
// One-stage SECDED encoder with a shadow encoder compare that poisons check bits on mismatch.
// Optional macro ECC_ENC_FAULT_CNT_EN adds a saturating 8-bit mismatch counter.
module ecc_177_enc_fault_detc #(
    parameter int DATA_WIDTH   = ecc_177_pkg::DATA_WIDTH,
    parameter int PARITY_WIDTH = ecc_177_pkg::PARITY_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ecc_fault_detc_en,
    input  logic                    bypass,
    input  logic                    fault_inj,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic [PARITY_WIDTH-1:0] parity_out,
    output logic                    ecc_fault,
    output logic                    fault_sticky,
    input  logic                    fault_clr,
    output logic [7:0]              fault_cnt
);
    import ecc_177_pkg::*;

    logic [DATA_WIDTH-1:0]   data_sdw;
    logic [PARITY_WIDTH-1:0] par_pri, par_sdw, par_sel;
    logic                    accept, mismatch;

    logic                    valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [PARITY_WIDTH-1:0] par_q, par_d;
    logic                    fault_q, fault_d;
    logic                    sticky_q, sticky_d;

    assign data_sdw = {data_in[DATA_WIDTH-1:1], data_in[0] ^ fault_inj};

    ecc_177_enc #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u0 (
        .data   (data_in),
        .parity (par_pri)
    );

    ecc_177_enc #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u1 (
        .data   (data_sdw),
        .parity (par_sdw)
    );

    assign in_ready = ~valid_q | out_ready;
    assign accept   = in_valid & in_ready;
    assign mismatch = ecc_fault_detc_en & ~bypass & (par_pri != par_sdw);

    // Poisoning bits 0 and 8 turns any received word into a detected double error.
    assign par_sel = bypass   ? '0 :
                     mismatch ? (par_pri ^ POISON_MASK) : par_pri;

    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        par_d    = par_q;
        fault_d  = fault_q;
        sticky_d = fault_clr ? 1'b0 : sticky_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = data_in;
            par_d   = par_sel;
            fault_d = mismatch;
            if (mismatch) begin
                sticky_d = 1'b1;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            par_q    <= '0;
            fault_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            par_q    <= par_d;
            fault_q  <= fault_d;
            sticky_q <= sticky_d;
        end
    end

    assign out_valid    = valid_q;
    assign data_out     = data_q;
    assign parity_out   = par_q;
    assign ecc_fault    = fault_q;
    assign fault_sticky = sticky_q;

`ifdef ECC_ENC_FAULT_CNT_EN
    logic [7:0] cnt_q, cnt_d;

    // A clear in the same cycle as a new mismatch leaves the count at one.
    always_comb begin
        cnt_d = fault_clr ? 8'd0 : cnt_q;
        if (accept && mismatch && (cnt_d != 8'hFF)) begin
            cnt_d = cnt_d + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fault_cnt = cnt_q;
`else
    assign fault_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_ecc_177_enc_fault_detc.sv
// Directed bench for ecc_177_enc_fault_detc with hand-computed check bits.
module tb_ecc_177_enc_fault_detc;

    localparam int DW = 177;
    localparam int PW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          en, byp, inj;
    logic          in_valid, in_ready;
    logic [DW-1:0] data_in;
    logic          out_valid, out_ready;
    logic [DW-1:0] data_out;
    logic [PW-1:0] parity_out;
    logic          ecc_fault, fault_sticky, fault_clr;
    logic [7:0]    fault_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] d_b0, d_b1, d_b3, d_b176, d_b01;
    logic [7:0]    cnt_one, cnt_sat;

    ecc_177_enc_fault_detc dut (
        .clk               (clk),
        .rst               (rst),
        .ecc_fault_detc_en (en),
        .bypass            (byp),
        .fault_inj         (inj),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .data_in           (data_in),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .data_out          (data_out),
        .parity_out        (parity_out),
        .ecc_fault         (ecc_fault),
        .fault_sticky      (fault_sticky),
        .fault_clr         (fault_clr),
        .fault_cnt         (fault_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted word with out_ready high; outputs are visible on return.
    task automatic send(input logic [DW-1:0] d, input logic e, input logic b, input logic i);
        data_in   = d;
        en        = e;
        byp       = b;
        inj       = i;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        en        = 1'b0;
        byp       = 1'b0;
        inj       = 1'b0;
    endtask

    initial begin
        d_b0   = '0; d_b0[0]     = 1'b1;
        d_b1   = '0; d_b1[1]     = 1'b1;
        d_b3   = '0; d_b3[3]     = 1'b1;
        d_b176 = '0; d_b176[176] = 1'b1;
        d_b01  = '0; d_b01[1:0]  = 2'b11;
`ifdef ECC_ENC_FAULT_CNT_EN
        cnt_one = 8'd1;
        cnt_sat = 8'd255;
`else
        cnt_one = 8'd0;
        cnt_sat = 8'd0;
`endif

        rst = 1'b1; en = 1'b1; byp = 1'b0; inj = 1'b1; fault_clr = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1; data_in = d_b0;
        tick(); tick(); tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_ecc_fault", ecc_fault, 0);
        check("rst_sticky", fault_sticky, 0);
        check("rst_cnt", fault_cnt, 0);
        check("rst_data", data_out, 0);
        check("rst_parity", parity_out, 0);

        rst = 1'b0; in_valid = 1'b0; inj = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);

        send('0, 1'b1, 1'b0, 1'b0);
        check("zero_valid", out_valid, 1);
        check("zero_parity", parity_out, 9'h000);
        check("zero_fault", ecc_fault, 0);

        send(d_b0, 1'b1, 1'b0, 1'b0);
        check("b0_parity", parity_out, 9'h103);
        check("b0_data", data_out, d_b0);
        check("b0_fault", ecc_fault, 0);

        send(d_b1, 1'b1, 1'b0, 1'b0);
        check("b1_parity", parity_out, 9'h105);
        send(d_b3, 1'b1, 1'b0, 1'b0);
        check("b3_parity", parity_out, 9'h007);
        send(d_b176, 1'b1, 1'b0, 1'b0);
        check("b176_parity", parity_out, 9'h0B9);
        send(d_b01, 1'b1, 1'b0, 1'b0);
        check("b01_parity", parity_out, 9'h006);
        check("no_fault_sticky", fault_sticky, 0);

        send(d_b0, 1'b1, 1'b0, 1'b1);
        check("inj_fault", ecc_fault, 1);
        check("inj_parity", parity_out, 9'h002);
        check("inj_sticky", fault_sticky, 1);
        check("inj_cnt", fault_cnt, cnt_one);

        send(d_b0, 1'b0, 1'b0, 1'b1);
        check("dis_fault", ecc_fault, 0);
        check("dis_parity", parity_out, 9'h103);
        check("dis_sticky", fault_sticky, 1);
        check("dis_cnt", fault_cnt, cnt_one);

        send(d_b0, 1'b1, 1'b1, 1'b1);
        check("byp_parity", parity_out, 9'h000);
        check("byp_fault", ecc_fault, 0);
        check("byp_cnt", fault_cnt, cnt_one);

        // Drain, then clear the sticky bit and the count without a new word.
        out_ready = 1'b1; fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("drain_valid", out_valid, 0);
        check("clr_sticky", fault_sticky, 0);
        check("clr_cnt", fault_cnt, 0);

        // Backpressure: word A stalls for three cycles while B waits.
        data_in = d_b0; en = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        data_in = d_b1;
        #1;
        check("bp_in_ready", in_ready, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("bp_valid", out_valid, 1);
            check("bp_data_hold", data_out, d_b0);
            check("bp_parity_hold", parity_out, 9'h103);
            check("bp_in_ready_hold", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", in_ready, 1);
        tick();
        check("bp_second_data", data_out, d_b1);
        check("bp_second_par", parity_out, 9'h105);
        data_in = d_b176;
        tick();
        check("bp_third_data", data_out, d_b176);
        check("bp_third_par", parity_out, 9'h0B9);
        in_valid = 1'b0;
        tick();
        check("bp_done_valid", out_valid, 0);

        for (int n = 0; n < 300; n++) begin
            send(d_b0, 1'b1, 1'b0, 1'b1);
        end
        check("sat_cnt", fault_cnt, cnt_sat);
        check("sat_sticky", fault_sticky, 1);

        fault_clr = 1'b1;
        send(d_b0, 1'b1, 1'b0, 1'b1);
        fault_clr = 1'b0;
        check("clr_hit_cnt", fault_cnt, cnt_one);
        check("clr_hit_sticky", fault_sticky, 1);
        check("clr_hit_fault", ecc_fault, 1);

        // Reset while a word is held must discard it.
        data_in = d_b3; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        check("hold_valid", out_valid, 1);
        rst = 1'b1; in_valid = 1'b0;
        tick();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", data_out, 0);
        check("mid_rst_sticky", fault_sticky, 0);
        check("mid_rst_cnt", fault_cnt, 0);
        rst = 1'b0;
        tick();
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_still_empty", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
